cprv_imem_responder: RTL

Instruction-memory responder sitting at the far end of the fetch stage's request/response interface. Accepts instruction-address requests, reads 32-bit instruction words from an internal synchronous RAM, and returns them zero-extended on a valid/ready response channel with backpressure. A side load port lets the testbench or boot logic write program words.

---
 rtl/cprv_pkg.sv | 30 +++
 rtl/cprv_sync_fifo.sv | 75 +++++++
 rtl/cprv_imem_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cprv_pkg.sv
// -----------------------------------------------------------------------------
// cprv_pkg
// Shared definitions for the CPRV instruction-memory path.
//   IMEM_WORD_WIDTH : width of one instruction word held in instruction memory
//   imem_resp_t     : one buffered response entry {err, data}
//   imemWordInRange : word index of a byte address lies inside the memory
//   imemFetchOk     : fetch address is word aligned and inside the memory
// -----------------------------------------------------------------------------
package cprv_pkg;

  localparam int IMEM_WORD_WIDTH = 32;

  typedef struct packed {
    logic                       err;
    logic [IMEM_WORD_WIDTH-1:0] data;
  } imem_resp_t;

  // Compares the full word index rather than the truncated RAM index, so
  // high address bits cannot alias back onto low words.
  function automatic logic imemWordInRange(input logic [63:0] addr,
                                           input logic [63:0] depthWords);
    return (addr >> 2) < depthWords;
  endfunction

  function automatic logic imemFetchOk(input logic [63:0] addr,
                                       input logic [63:0] depthWords);
    return (addr[1:0] == 2'b00) && imemWordInRange(addr, depthWords);
  endfunction

endpackage

// File: rtl/cprv_sync_fifo.sv
// -----------------------------------------------------------------------------
// cprv_sync_fifo
// Small synchronous FIFO with registered head output.
//   clk, rst  : clock and synchronous active-high reset
//   push_i    : write data_i (ignored when full)
//   data_i    : entry to write
//   pop_i     : remove head entry (ignored when empty)
//   data_o    : current head entry, taken straight from storage registers
//   full_o    : DEPTH entries held
//   empty_o   : no entries held
// -----------------------------------------------------------------------------
module cprv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] storage_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign data_o  = storage_q[rdPtr_q];

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = nextPtr(wrPtr_q);
    if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head output reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) storage_q[i] <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      if (doPush) storage_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/cprv_imem_responder.sv
// -----------------------------------------------------------------------------
// cprv_imem_responder
// Instruction-memory responder for the fetch stage. Requests are read from an
// internal synchronous RAM and returned in order, zero-extended, on a
// valid/ready response channel. A side load port writes program words.
//   clk, rst        : clock and synchronous active-high reset
//   req_valid_i     : fetch request valid
//   req_ready_o     : request accepted when valid & ready at a clock edge
//   req_addr_i      : instruction byte address
//   resp_valid_o    : response valid
//   resp_ready_i    : response consumed when valid & ready
//   resp_data_o     : {zeros, instr[31:0]}, zero for error responses
//   resp_err_o      : request was misaligned or out of range
//   load_we_i       : program-load write enable
//   load_addr_i     : program-load byte address (bits [1:0] ignored)
//   load_data_i     : program-load data, low 32 bits stored
// -----------------------------------------------------------------------------
module cprv_imem_responder
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 64,
  parameter int DEPTH_WORDS = 1024,
  parameter int RESP_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_err_o,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [IMEM_WORD_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [IMEM_WORD_WIDTH-1:0] rdWord_q;
  logic                       rdErr_q;
  logic                       inFlight_q;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic             reqAccept;
  logic             respPop;
  logic             reqOk;
  logic             loadOk;
  logic [IDX_W-1:0] reqIdx;
  logic [IDX_W-1:0] loadIdx;
  imem_resp_t       pushEntry;
  imem_resp_t       headEntry;
  logic             fifoEmpty;
  logic             unusedFifoFull;
  logic             unusedLoadBits;

  assign reqAccept = req_valid_i & req_ready_o;
  assign respPop   = resp_valid_o & resp_ready_i;
  assign reqOk     = imemFetchOk(64'(req_addr_i), 64'(DEPTH_WORDS));
  assign loadOk    = imemWordInRange(64'(load_addr_i), 64'(DEPTH_WORDS));
  assign reqIdx    = req_addr_i[IDX_W+1:2];
  assign loadIdx   = load_addr_i[IDX_W+1:2];

  assign unusedLoadBits = ^{load_data_i[DATA_WIDTH-1:IMEM_WORD_WIDTH], load_addr_i[1:0]};

  // Credit check uses only registered state, so ready never depends on
  // resp_ready_i in the same cycle.
  assign req_ready_o = (cnt_q < CNT_W'(RESP_DEPTH)) & ~rst;

  // Read and write in one process with non-blocking assignments: a read of
  // the word being loaded on the same edge returns the old contents.
  always_ff @(posedge clk) begin
    if (load_we_i && loadOk) mem[loadIdx] <= load_data_i[IMEM_WORD_WIDTH-1:0];
    if (reqAccept)           rdWord_q     <= mem[reqIdx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inFlight_q <= 1'b0;
      rdErr_q    <= 1'b0;
    end else begin
      inFlight_q <= reqAccept;
      rdErr_q    <= reqAccept & ~reqOk;
    end
  end

  // cnt counts reads in flight plus responses buffered, bounding the FIFO
  // occupancy so a push can never find it full.
  always_comb begin
    cnt_d = cnt_q;
    case ({reqAccept, respPop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign pushEntry.err  = rdErr_q;
  assign pushEntry.data = rdErr_q ? '0 : rdWord_q;

  cprv_sync_fifo #(
    .WIDTH ($bits(imem_resp_t)),
    .DEPTH (RESP_DEPTH)
  ) respFifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inFlight_q),
    .data_i  (pushEntry),
    .pop_i   (resp_ready_i),
    .data_o  (headEntry),
    .full_o  (unusedFifoFull),
    .empty_o (fifoEmpty)
  );

  assign resp_valid_o = ~fifoEmpty;
  assign resp_err_o   = headEntry.err;
  assign resp_data_o  = {{(DATA_WIDTH-IMEM_WORD_WIDTH){1'b0}}, headEntry.data};

endmodule
